// File: rtl/demux1to3_buf.sv
// 1-to-3 valid/ready routing buffer with one output register per port.
// Select 2'b11 consumes the word and increments a saturating drop counter.
module demux1to3_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [CNT_W-1:0] drop_count
);

  typedef enum logic [1:0] {
    SEL_P0   = 2'b00,
    SEL_P1   = 2'b01,
    SEL_P2   = 2'b10,
    SEL_DROP = 2'b11
  } sel_e;

  sel_e             sel;
  logic [2:0]       vld;
  logic [2:0]       rdy;
  logic [2:0]       room;
  logic [2:0]       load;
  logic             accept;
  logic             drop;
  logic [WIDTH-1:0] dat [3];

  assign sel = sel_e'(in_sel);

  // A port has room when empty or draining this cycle, so a full port
  // with a ready consumer still takes one word per cycle.
  always_comb begin
    rdy      = {out2_ready, out1_ready, out0_ready};
    room     = ~vld | rdy;
    in_ready = 1'b0;
    if (!reset) begin
      case (sel)
        SEL_P0:  in_ready = room[0];
        SEL_P1:  in_ready = room[1];
        SEL_P2:  in_ready = room[2];
        default: in_ready = 1'b1;
      endcase
    end
    accept = in_valid & in_ready;
    load   = '0;
    drop   = 1'b0;
    case (sel)
      SEL_P0:  load[0] = accept;
      SEL_P1:  load[1] = accept;
      SEL_P2:  load[2] = accept;
      default: drop    = accept;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld        <= '0;
      drop_count <= '0;
      for (int unsigned k = 0; k < 3; k++) begin
        dat[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 3; k++) begin
        if (load[k]) begin
          dat[k] <= in_data;
          vld[k] <= 1'b1;
        end else if (rdy[k]) begin
          vld[k] <= 1'b0;
        end
      end
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

  assign out0_data  = dat[0];
  assign out1_data  = dat[1];
  assign out2_data  = dat[2];
  assign out0_valid = vld[0];
  assign out1_valid = vld[1];
  assign out2_valid = vld[2];

endmodule

// File: tb/tb_demux1to3_buf.sv
// Bench for demux1to3_buf: vector table plus hand sequences, with a per-port
// scoreboard of expected words checked on every output transfer.
module tb_demux1to3_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out0_data, out1_data, out2_data;
  logic        out0_valid, out1_valid, out2_valid;
  logic        out0_ready, out1_ready, out2_ready;
  logic [7:0]  drop_count;

  int tests = 0;
  int fails = 0;

  logic [31:0] q [3][$];
  logic [2:0]  pend;
  logic [31:0] pdat [3];

  typedef struct {
    logic [31:0] data;
    logic [1:0]  sel;
    logic        valid;
    logic [2:0]  rdy;
    logic        exp_irdy;
    logic [2:0]  exp_vld;
  } vec_t;

  vec_t tbl [14];

  demux1to3_buf #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] odat(input int k);
    case (k)
      0:       return out0_data;
      1:       return out1_data;
      default: return out2_data;
    endcase
  endfunction

  // Waits for the mid-cycle sample point and runs the scoreboard there:
  // latency check for last cycle's acceptance, pop on drain, push on accept.
  task automatic step();
    logic [2:0] ov, orr;
    @(negedge clk);
    ov  = {out2_valid, out1_valid, out0_valid};
    orr = {out2_ready, out1_ready, out0_ready};
    for (int k = 0; k < 3; k++) begin
      if (pend[k]) begin
        chk($sformatf("latency_valid%0d", k), 64'(ov[k]), 64'd1);
        chk($sformatf("latency_data%0d", k), 64'(odat(k)), 64'(pdat[k]));
        pend[k] = 1'b0;
      end
    end
    if (reset === 1'b1) begin
      for (int k = 0; k < 3; k++) q[k].delete();
      pend = '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (ov[k] === 1'b1 && orr[k] === 1'b1) begin
          if (q[k].size() == 0) chk($sformatf("unexpected_word%0d", k), 64'(odat(k)), 64'hFFFF_FFFF_FFFF_FFFF);
          else chk($sformatf("order%0d", k), 64'(odat(k)), 64'(q[k].pop_front()));
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1 && in_sel != 2'b11) begin
        q[in_sel].push_back(in_data);
        pend[in_sel] = 1'b1;
        pdat[in_sel] = in_data;
      end
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [1:0] s, input logic v, input logic [2:0] r);
    @(posedge clk);
    #2;
    in_data    = d;
    in_sel     = s;
    in_valid   = v;
    out0_ready = r[0];
    out1_ready = r[1];
    out2_ready = r[2];
  endtask

  initial begin
    pend       = '0;
    reset      = 1'b1;
    in_data    = 32'hDEAD_BEEF;
    in_sel     = 2'b00;
    in_valid   = 1'b1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    out2_ready = 1'b1;

    // reset held two cycles with a valid word presented
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_valids", 64'({out2_valid, out1_valid, out0_valid}), 64'd0);
      chk("rst_data0", 64'(out0_data), 64'd0);
      chk("rst_data1", 64'(out1_data), 64'd0);
      chk("rst_data2", 64'(out2_data), 64'd0);
      chk("rst_drop", 64'(drop_count), 64'd0);
    end
    @(posedge clk);
    #2;
    reset    = 1'b0;
    in_valid = 1'b0;

    // routing and port-1 backpressure
    tbl[0]  = '{32'hA0000001, 2'd0, 1'b1, 3'b111, 1'b1, 3'b000};
    tbl[1]  = '{32'hB0000002, 2'd1, 1'b1, 3'b111, 1'b1, 3'b001};
    tbl[2]  = '{32'hC0000003, 2'd2, 1'b1, 3'b111, 1'b1, 3'b010};
    tbl[3]  = '{32'h0,        2'd0, 1'b0, 3'b111, 1'b1, 3'b100};
    tbl[4]  = '{32'h0,        2'd0, 1'b0, 3'b111, 1'b1, 3'b000};
    tbl[5]  = '{32'h11,       2'd1, 1'b1, 3'b101, 1'b1, 3'b000};
    tbl[6]  = '{32'h22,       2'd1, 1'b1, 3'b101, 1'b0, 3'b010};
    tbl[7]  = '{32'h33,       2'd0, 1'b1, 3'b101, 1'b1, 3'b010};
    tbl[8]  = '{32'h22,       2'd1, 1'b1, 3'b101, 1'b0, 3'b011};
    tbl[9]  = '{32'h22,       2'd1, 1'b1, 3'b111, 1'b1, 3'b010};
    tbl[10] = '{32'h0,        2'd1, 1'b0, 3'b101, 1'b0, 3'b010};
    tbl[11] = '{32'h0,        2'd3, 1'b0, 3'b101, 1'b1, 3'b010};
    tbl[12] = '{32'h0,        2'd1, 1'b0, 3'b111, 1'b1, 3'b010};
    tbl[13] = '{32'h0,        2'd0, 1'b0, 3'b111, 1'b1, 3'b000};
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].data, tbl[i].sel, tbl[i].valid, tbl[i].rdy);
      step();
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].exp_irdy));
      chk($sformatf("vec%0d_valids", i), 64'({out2_valid, out1_valid, out0_valid}), 64'(tbl[i].exp_vld));
      chk($sformatf("vec%0d_drop", i), 64'(drop_count), 64'd0);
    end

    // back-to-back throughput on port 2
    for (int i = 0; i < 8; i++) begin
      drive(32'h400 + 32'(i), 2'd2, 1'b1, 3'b111);
      step();
      chk("thr_in_ready", 64'(in_ready), 64'd1);
      if (i > 0) chk("thr_valid", 64'(out2_valid), 64'd1);
    end
    drive(32'h0, 2'd0, 1'b0, 3'b111);
    step();
    chk("thr_last_valid", 64'(out2_valid), 64'd1);
    chk("thr_last_data", 64'(out2_data), 64'h407);
    drive(32'h0, 2'd0, 1'b0, 3'b111);
    step();
    chk("thr_empty", 64'(out2_valid), 64'd0);

    // drops with counter saturation
    for (int i = 0; i < 300; i++) begin
      drive(32'(i), 2'd3, 1'b1, 3'b111);
      step();
      chk("drop_in_ready", 64'(in_ready), 64'd1);
      chk("drop_valids", 64'({out2_valid, out1_valid, out0_valid}), 64'd0);
      chk("drop_count", 64'(drop_count), 64'((i < 255) ? i : 255));
    end
    for (int i = 0; i < 2; i++) begin
      drive(32'h0, 2'd3, 1'b0, 3'b111);
      step();
      chk("drop_hold", 64'(drop_count), 64'd255);
    end

    // reset while ports 0 and 2 are full and stalled
    drive(32'h600, 2'd0, 1'b1, 3'b010);
    step();
    drive(32'h602, 2'd2, 1'b1, 3'b010);
    step();
    drive(32'h0, 2'd0, 1'b0, 3'b010);
    step();
    chk("mid_full", 64'({out2_valid, out1_valid, out0_valid}), 64'b101);
    chk("mid_full_sel0_blocked", 64'(in_ready), 64'd0);
    @(posedge clk);
    #2;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_sel   = 2'd1;
    in_data  = 32'h6FF;
    step();
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_before_edge", 64'({out2_valid, out1_valid, out0_valid}), 64'b101);
    @(posedge clk);
    #2;
    reset    = 1'b0;
    in_valid = 1'b0;
    step();
    chk("mid_rst_valids", 64'({out2_valid, out1_valid, out0_valid}), 64'd0);
    chk("mid_rst_drop", 64'(drop_count), 64'd0);
    chk("mid_rst_data0", 64'(out0_data), 64'd0);
    chk("mid_rst_data2", 64'(out2_data), 64'd0);
    drive(32'h6AB, 2'd0, 1'b1, 3'b111);
    step();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    drive(32'h0, 2'd0, 1'b0, 3'b111);
    step();
    chk("post_rst_valid", 64'(out0_valid), 64'd1);
    chk("post_rst_data", 64'(out0_data), 64'h6AB);
    drive(32'h0, 2'd0, 1'b0, 3'b111);
    step();
    chk("post_rst_empty", 64'({out2_valid, out1_valid, out0_valid}), 64'd0);

    for (int k = 0; k < 3; k++) begin
      chk($sformatf("sb_left%0d", k), 64'(q[k].size()), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
